vend_ctrl: RTL and testbench



---
 rtl/vend_pkg.sv | 31 +++
 rtl/vend_credit.sv | 43 ++++
 rtl/vend_ctrl.sv | 148 ++++++++++++++
 tb/tb_vend_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared definitions for the vending controller: FSM state encoding, coin values,
// and the credit-register control bundle.
package vend_pkg;

    localparam logic [1:0] ST_ACCUM  = 2'd0;
    localparam logic [1:0] ST_VEND   = 2'd1;
    localparam logic [1:0] ST_CHANGE = 2'd2;

    localparam logic [1:0] COIN1_VAL = 2'd1;
    localparam logic [1:0] COIN2_VAL = 2'd2;

    typedef struct packed {
        logic       add_en;
        logic [1:0] add_val;
        logic       sub_price;
        logic       dec_one;
    } credit_ctl_t;

    // Value of a single accepted coin; the both-coins case is handled by the caller.
    function automatic logic [1:0] coin_value(input logic e1, input logic e2);
        logic [1:0] val;
        val = 2'd0;
        if (e1 && !e2) begin
            val = COIN1_VAL;
        end else if (e2 && !e1) begin
            val = COIN2_VAL;
        end
        return val;
    endfunction

endpackage

// File: rtl/vend_credit.sv
// Credit register of the vending controller: add-coin, subtract-price and
// decrement-by-one operations, plus the credit >= PRICE flag.
module vend_credit #(
    parameter int PRICE    = 3,
    parameter int CREDIT_W = 3
) (
    input  logic                clk,
    input  logic                srst,
    input  logic                add_en,
    input  logic [1:0]          add_val,
    input  logic                sub_price,
    input  logic                dec_one,
    output logic [CREDIT_W-1:0] credit,
    output logic                ge_price
);

    logic [CREDIT_W-1:0] credit_reg;
    logic [CREDIT_W-1:0] credit_next;

    // The FSM asserts at most one control per cycle; the order only fixes a priority.
    always_comb begin
        credit_next = credit_reg;
        if (sub_price) begin
            credit_next = credit_reg - CREDIT_W'(PRICE);
        end else if (dec_one) begin
            credit_next = credit_reg - CREDIT_W'(1);
        end else if (add_en) begin
            credit_next = credit_reg + CREDIT_W'(add_val);
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            credit_reg <= '0;
        end else begin
            credit_reg <= credit_next;
        end
    end

    assign credit   = credit_reg;
    assign ge_price = (credit_reg >= CREDIT_W'(PRICE));

endmodule

// File: rtl/vend_ctrl.sv
// Vending controller: credit accumulation, dispense handshake and change return.
// Optional dispense-ack timeout with full refund when VEND_TIMEOUT_EN is defined.
module vend_ctrl
    import vend_pkg::*;
#(
    parameter int PRICE    = 3,
    parameter int CREDIT_W = 3,
    parameter int TIMEOUT  = 15
) (
    input  logic                c,
    input  logic                r,
    input  logic                e1,
    input  logic                e2,
    input  logic                cancel,
    input  logic                dispense_ack,
    output logic                dispense_req,
    output logic                change_pulse,
    output logic                coin_rej,
    output logic                vend_fail,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy
);

    if (PRICE < 1) begin : g_bad_price
        $error("vend_ctrl: PRICE must be >= 1");
    end
    if (PRICE + 1 >= (2 ** CREDIT_W)) begin : g_bad_width
        $error("vend_ctrl: CREDIT_W too narrow for PRICE+1");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("vend_ctrl: TIMEOUT must be >= 1");
    end

    logic [1:0]          state_reg;
    logic [1:0]          state_next;
    logic                coin_rej_reg;
    logic                coin_rej_next;
    logic                ge_price;
    logic                timeout_hit;
    logic [CREDIT_W-1:0] credit_cur;
    credit_ctl_t         ctl;

    vend_credit #(
        .PRICE    (PRICE),
        .CREDIT_W (CREDIT_W)
    ) u_credit (
        .clk       (c),
        .srst      (r),
        .add_en    (ctl.add_en),
        .add_val   (ctl.add_val),
        .sub_price (ctl.sub_price),
        .dec_one   (ctl.dec_one),
        .credit    (credit_cur),
        .ge_price  (ge_price)
    );

`ifdef VEND_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] tmo_cnt_reg;
    logic             vend_fail_reg;

    // Counter sits at zero outside ST_VEND, so it is clear on every entry.
    always_ff @(posedge c) begin
        if (r || state_reg != ST_VEND) begin
            tmo_cnt_reg <= '0;
        end else begin
            tmo_cnt_reg <= tmo_cnt_reg + CNT_W'(1);
        end
    end

    // An ack in the final waiting cycle takes precedence over the timeout.
    assign timeout_hit = (state_reg == ST_VEND) && !dispense_ack &&
                         (tmo_cnt_reg == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge c) begin
        if (r) begin
            vend_fail_reg <= 1'b0;
        end else begin
            vend_fail_reg <= timeout_hit;
        end
    end

    assign vend_fail = vend_fail_reg;
`else
    assign timeout_hit = 1'b0;
    assign vend_fail   = 1'b0;
`endif

    always_comb begin
        state_next    = state_reg;
        coin_rej_next = 1'b0;
        ctl           = '0;
        case (state_reg)
            ST_ACCUM: begin
                // A completed price is served before any coin in the same cycle.
                if (ge_price) begin
                    state_next    = ST_VEND;
                    coin_rej_next = e1 | e2;
                end else if (cancel && credit_cur != '0) begin
                    state_next    = ST_CHANGE;
                    coin_rej_next = e1 | e2;
                end else if (e1 && e2) begin
                    coin_rej_next = 1'b1;
                end else if (e1 || e2) begin
                    ctl.add_en  = 1'b1;
                    ctl.add_val = coin_value(e1, e2);
                end
            end
            ST_VEND: begin
                coin_rej_next = e1 | e2;
                if (dispense_ack) begin
                    ctl.sub_price = 1'b1;
                    state_next    = (credit_cur == CREDIT_W'(PRICE)) ? ST_ACCUM : ST_CHANGE;
                end else if (timeout_hit) begin
                    state_next = ST_CHANGE;
                end
            end
            ST_CHANGE: begin
                coin_rej_next = e1 | e2;
                ctl.dec_one   = 1'b1;
                if (credit_cur == CREDIT_W'(1)) begin
                    state_next = ST_ACCUM;
                end
            end
            default: begin
                state_next = ST_ACCUM;
            end
        endcase
    end

    always_ff @(posedge c) begin
        if (r) begin
            state_reg    <= ST_ACCUM;
            coin_rej_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            coin_rej_reg <= coin_rej_next;
        end
    end

    assign dispense_req = (state_reg == ST_VEND);
    assign change_pulse = (state_reg == ST_CHANGE);
    assign busy         = (state_reg != ST_ACCUM);
    assign coin_rej     = coin_rej_reg;
    assign credit       = credit_cur;

endmodule

// File: tb/tb_vend_ctrl.sv
// Directed plus randomized bench for vend_ctrl, checked against a rule-level
// model of the vending behaviour (balance, phase, refund countdown).
module tb_vend_ctrl;

    localparam int PRICE    = 3;
    localparam int CREDIT_W = 3;
    localparam int TIMEOUT  = 15;
`ifdef VEND_TIMEOUT_EN
    localparam bit TMO_ON = 1'b1;
`else
    localparam bit TMO_ON = 1'b0;
`endif

    logic                c = 1'b0;
    logic                r;
    logic                e1;
    logic                e2;
    logic                cancel;
    logic                dispense_ack;
    logic                dispense_req;
    logic                change_pulse;
    logic                coin_rej;
    logic                vend_fail;
    logic [CREDIT_W-1:0] credit;
    logic                busy;

    always #5 c = ~c;

    vend_ctrl #(
        .PRICE    (PRICE),
        .CREDIT_W (CREDIT_W),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .c            (c),
        .r            (r),
        .e1           (e1),
        .e2           (e2),
        .cancel       (cancel),
        .dispense_ack (dispense_ack),
        .dispense_req (dispense_req),
        .change_pulse (change_pulse),
        .coin_rej     (coin_rej),
        .vend_fail    (vend_fail),
        .credit       (credit),
        .busy         (busy)
    );

    int  checks   = 0;
    int  failures = 0;
    int  step_no  = 0;
    int  pulses   = 0;

    // Model: customer balance, phase ("A" accepting, "V" vending, "C" refunding),
    // cycles spent waiting for the dispenser, and last-cycle pulse outputs.
    int  m_credit = 0;
    byte m_mode   = "A";
    int  m_wait   = 0;
    bit  m_rej    = 1'b0;
    bit  m_fail   = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s step=%0d observed=%0d expected=%0d", tag, step_no, obs, exp);
        end
    endtask

    task automatic model(input bit i_r, input bit i_e1, input bit i_e2,
                         input bit i_cancel, input bit i_ack);
        m_rej  = 1'b0;
        m_fail = 1'b0;
        if (i_r) begin
            m_mode   = "A";
            m_credit = 0;
        end else if (m_mode == "A") begin
            if (m_credit >= PRICE) begin
                m_mode = "V";
                m_wait = 0;
                m_rej  = i_e1 | i_e2;
            end else if (i_cancel && m_credit > 0) begin
                m_mode = "C";
                m_rej  = i_e1 | i_e2;
            end else if (i_e1 && i_e2) begin
                m_rej = 1'b1;
            end else begin
                m_credit = m_credit + (i_e1 ? 1 : 0) + (i_e2 ? 2 : 0);
            end
        end else if (m_mode == "V") begin
            m_rej = i_e1 | i_e2;
            if (i_ack) begin
                m_credit = m_credit - PRICE;
                m_mode   = (m_credit > 0) ? "C" : "A";
            end else if (TMO_ON) begin
                m_wait++;
                if (m_wait == TIMEOUT) begin
                    m_fail = 1'b1;
                    m_mode = "C";
                end
            end
        end else begin
            m_rej    = i_e1 | i_e2;
            m_credit = m_credit - 1;
            if (m_credit == 0) m_mode = "A";
        end
    endtask

    task automatic step(input bit i_r, input bit i_e1, input bit i_e2,
                        input bit i_cancel, input bit i_ack);
        r            = i_r;
        e1           = i_e1;
        e2           = i_e2;
        cancel       = i_cancel;
        dispense_ack = i_ack;
        @(posedge c);
        model(i_r, i_e1, i_e2, i_cancel, i_ack);
        #1;
        step_no++;
        chk("credit",       32'(credit),       32'(m_credit));
        chk("dispense_req", 32'(dispense_req), 32'(m_mode == "V"));
        chk("change_pulse", 32'(change_pulse), 32'(m_mode == "C"));
        chk("busy",         32'(busy),         32'(m_mode != "A"));
        chk("coin_rej",     32'(coin_rej),     32'(m_rej));
        chk("vend_fail",    32'(vend_fail),    32'(m_fail));
        if (change_pulse === 1'b1) pulses++;
        $display("step %0d r=%0b e1=%0b e2=%0b cn=%0b ack=%0b | credit=%0d req=%0b chg=%0b rej=%0b fail=%0b busy=%0b",
                 step_no, i_r, i_e1, i_e2, i_cancel, i_ack,
                 credit, dispense_req, change_pulse, coin_rej, vend_fail, busy);
    endtask

    initial begin
        // Reset with coins toggling
        step(1, 1, 0, 0, 0);
        step(1, 0, 1, 0, 0);

        // Exact price: three 1-unit coins, ack two cycles into ST_VEND
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);

        // Overpay: two 2-unit coins, one unit of change
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);

        // Rejects: both coins at once, then a coin while vending
        step(0, 1, 1, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);

        // Cancel at credit 2 yields exactly two change pulses
        step(0, 0, 1, 0, 0);
        pulses = 0;
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("cancel_pulses", 32'(pulses), 32'd2);
        step(0, 0, 0, 1, 0);

        // Reset during change return
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);

`ifdef VEND_TIMEOUT_EN
        // No ack: timeout after TIMEOUT cycles of dispense_req, full refund
        step(0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        pulses = 0;
        for (int i = 0; i < TIMEOUT + 5; i++) step(0, 0, 0, 0, 0);
        chk("timeout_pulses", 32'(pulses), 32'd3);
`endif

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            int k;
            bit rr, a1, a2, cn, ak;
            k  = int'($urandom_range(0, 9));
            rr = ($urandom_range(0, 79) == 0);
            a1 = (k <= 2) || (k == 5);
            a2 = (k == 3) || (k == 4) || (k == 5);
            cn = (k == 6);
            ak = ($urandom_range(0, 3) == 0);
            step(rr, a1, a2, cn, ak);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
